// File: rtl/pll_reset_sequencer_if.sv
// PLL/core-side signal bundle for pll_reset_sequencer.
// The master modport is the sequencer; the slave modport is the PLL plus core-reset consumer.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic [7:0] lock_loss_cnt;
    logic [3:0] retry_cnt;

    modport master (
        input  pll_locked,
        input  relock_req,
        output pll_rst,
        output core_rst,
        output ready,
        output lock_loss_cnt,
        output retry_cnt
    );

    modport slave (
        output pll_locked,
        output relock_req,
        input  pll_rst,
        input  core_rst,
        input  ready,
        input  lock_loss_cnt,
        input  retry_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Refclk-domain PLL reset / lock-qualification sequencer producing a glitch-free core reset.
// Optional lock-wait timeout with retry counting is enabled by defining PLL_SEQ_TIMEOUT_EN.
module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W               = 21
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_reset_sequencer_if.master pll
);

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        QUALIFY   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int MAX_HS   = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_CEIL = (MAX_HS > LOCK_TIMEOUT_CYCLES) ? MAX_HS : LOCK_TIMEOUT_CYCLES;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    // The counter never needs to exceed the largest configured count; it parks there instead of wrapping.
    localparam logic [CNT_W-1:0] CNT_TOP     = CNT_W'(CNT_CEIL - 1);
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_TOP) ? v : (v + CNT_W'(1));
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

`ifdef PLL_SEQ_TIMEOUT_EN
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : (v + 4'd1);
    endfunction
`endif

    logic             sync_meta_r;
    logic             lk_sync_r;
    logic             lk_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [7:0]       loss_cnt_r;
    logic [7:0]       loss_nxt_s;
    logic             pll_rst_r;
    logic             core_rst_r;
    logic             ready_r;
`ifdef PLL_SEQ_TIMEOUT_EN
    logic [3:0]       retry_cnt_r;
    logic [3:0]       retry_nxt_s;
`endif

    assign lk_s = lk_sync_r;

    // Next-state, counter and event-count decode; relock outranks lock events
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        loss_nxt_s  = loss_cnt_r;
`ifdef PLL_SEQ_TIMEOUT_EN
        retry_nxt_s = retry_cnt_r;
`endif
        if (pll.relock_req && (state_r != PLL_RESET)) begin
            state_nxt_s = PLL_RESET;
            cnt_nxt_s   = {CNT_W{1'b0}};
            // A lock loss coinciding with the relock is still recorded
            if ((state_r == RUN) && !lk_s) begin
                loss_nxt_s = sat_inc8(loss_cnt_r);
            end else begin
                loss_nxt_s = loss_cnt_r;
            end
        end else begin
            case (state_r)
                PLL_RESET: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_nxt_s = WAIT_LOCK;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_inc(cnt_r);
                    end
                end
                WAIT_LOCK: begin
                    if (lk_s) begin
                        state_nxt_s = QUALIFY;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
`ifdef PLL_SEQ_TIMEOUT_EN
                        if (cnt_r == TIMEOUT_LAST) begin
                            state_nxt_s = PLL_RESET;
                            cnt_nxt_s   = {CNT_W{1'b0}};
                            retry_nxt_s = sat_inc4(retry_cnt_r);
                        end else begin
                            cnt_nxt_s = cnt_inc(cnt_r);
                        end
`else
                        cnt_nxt_s = cnt_r;
`endif
                    end
                end
                QUALIFY: begin
                    // A dropout restarts qualification without touching the PLL
                    if (!lk_s) begin
                        cnt_nxt_s = {CNT_W{1'b0}};
                    end else if (cnt_r == STABLE_LAST) begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_inc(cnt_r);
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state_nxt_s = PLL_RESET;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        loss_nxt_s  = sat_inc8(loss_cnt_r);
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                default: begin
                    state_nxt_s = PLL_RESET;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Synchronizer, FSM state, counters and outputs registered from the next state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 1'b0;
            lk_sync_r   <= 1'b0;
            state_r     <= PLL_RESET;
            cnt_r       <= {CNT_W{1'b0}};
            loss_cnt_r  <= 8'd0;
            pll_rst_r   <= 1'b1;
            core_rst_r  <= 1'b1;
            ready_r     <= 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
            retry_cnt_r <= 4'd0;
`endif
        end else begin
            sync_meta_r <= pll.pll_locked;
            lk_sync_r   <= sync_meta_r;
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            loss_cnt_r  <= loss_nxt_s;
            pll_rst_r   <= (state_nxt_s == PLL_RESET);
            core_rst_r  <= (state_nxt_s != RUN);
            ready_r     <= (state_nxt_s == RUN);
`ifdef PLL_SEQ_TIMEOUT_EN
            retry_cnt_r <= retry_nxt_s;
`endif
        end
    end

    assign pll.pll_rst       = pll_rst_r;
    assign pll.core_rst      = core_rst_r;
    assign pll.ready         = ready_r;
    assign pll.lock_loss_cnt = loss_cnt_r;
`ifdef PLL_SEQ_TIMEOUT_EN
    assign pll.retry_cnt     = retry_cnt_r;
`else
    assign pll.retry_cnt     = 4'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: stimulus queues expected output changes
// (cycle + value); a negedge monitor pops and compares whenever the outputs change.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    localparam int HOLD   = 4;
    localparam int STABLE = 8;
    localparam int TMO    = 32;

    typedef struct {
        int          cyc;
        logic [14:0] val;
    } exp_t;

    logic        refclk = 1'b0;
    logic        rst    = 1'b0;
    int          cyc    = 0;
    int          tests  = 0;
    int          fails  = 0;
    bit          mon_en = 1'b0;
    logic [14:0] prev_v;
    logic [14:0] obs_v;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          exp_ll = 0;
    int          exp_rt = 0;
    int          base   = 0;
    int          w      = 0;

    pll_reset_sequencer_if pif();

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES    (HOLD),
        .LOCK_STABLE_CYCLES (STABLE),
        .LOCK_TIMEOUT_CYCLES(TMO),
        .CNT_W              (21)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .pll   (pif)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    assign obs_v = {pif.pll_rst, pif.core_rst, pif.ready, pif.lock_loss_cnt, pif.retry_cnt};

    function automatic logic [14:0] vec(input logic p, input logic c, input logic r,
                                        input int ll, input int rt);
        logic [7:0] l8;
        logic [3:0] r4;
        l8 = ll[7:0];
        r4 = rt[3:0];
        return {p, c, r, l8, r4};
    endfunction

    function automatic string vstr(input logic [14:0] v);
        return $sformatf("pll_rst=%0b core_rst=%0b ready=%0b loss=%0d retry=%0d",
                         v[14], v[13], v[12], v[11:4], v[3:0]);
    endfunction

    task automatic expect_at(input int c, input logic [14:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic pulse_relock();
        pif.relock_req = 1'b1;
        @(posedge refclk);
        #1;
        pif.relock_req = 1'b0;
    endtask

    // Monitor: every output change must match the next queued expectation, cycle-exact
    always @(negedge refclk) begin
        if (mon_en && (obs_v !== prev_v)) begin
            tests = tests + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_event cyc=%0d got {%s}", cyc, vstr(obs_v));
            end else begin
                mon_e = exp_q.pop_front();
                if ((mon_e.cyc != cyc) || (mon_e.val !== obs_v)) begin
                    fails = fails + 1;
                    $display("FAIL event got cyc=%0d {%s} expected cyc=%0d {%s}",
                             cyc, vstr(obs_v), mon_e.cyc, vstr(mon_e.val));
                end
            end
            prev_v = obs_v;
        end
    end

    initial begin
        pif.pll_locked = 1'b0;
        pif.relock_req = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge refclk);
        #1;
        tests = tests + 1;
        if (obs_v !== vec(1'b1, 1'b1, 1'b0, 0, 0)) begin
            fails = fails + 1;
            $display("FAIL reset_state got {%s} expected {%s}", vstr(obs_v), vstr(vec(1'b1, 1'b1, 1'b0, 0, 0)));
        end
        prev_v = vec(1'b1, 1'b1, 1'b0, 0, 0);
        mon_en = 1'b1;

        // Release: pll_rst held exactly HOLD cycles
        rst  = 1'b0;
        base = cyc;
        expect_at(base + HOLD, vec(1'b0, 1'b1, 1'b0, 0, 0));
        wait_to(base + HOLD);

        // Lock 10 cycles after pll_rst falls: 2 sync + 1 entry + STABLE qualify
        wait_to(cyc + 10);
        base = cyc;
        pif.pll_locked = 1'b1;
        expect_at(base + 3 + STABLE, vec(1'b0, 1'b0, 1'b1, 0, 0));
        wait_to(base + 3 + STABLE + 3);

        // Relock in RUN with lock good: reset pulse, then requalify
        base = cyc;
        expect_at(base + 1, vec(1'b1, 1'b1, 1'b0, 0, 0));
        expect_at(base + 1 + HOLD, vec(1'b0, 1'b1, 1'b0, 0, 0));
        expect_at(base + 2 + HOLD + STABLE, vec(1'b0, 1'b0, 1'b1, 0, 0));
        pulse_relock();
        wait_to(base + 2 + HOLD + STABLE + 2);

        // Relock coinciding with lock loss, then a second relock inside PLL_RESET
        base = cyc;
        pif.pll_locked = 1'b0;
        exp_ll = 1;
        expect_at(base + 3, vec(1'b1, 1'b1, 1'b0, exp_ll, 0));
        expect_at(base + 3 + HOLD, vec(1'b0, 1'b1, 1'b0, exp_ll, 0));
        wait_to(base + 2);
        pulse_relock();
        wait_to(base + 5);
        pulse_relock();
        wait_to(base + 3 + HOLD + 3);

        // Qualification dropout after 5 good cycles restarts the count
        base = cyc;
        pif.pll_locked = 1'b1;
        expect_at(base + 17, vec(1'b0, 1'b0, 1'b1, exp_ll, 0));
        wait_to(base + 6);
        pif.pll_locked = 1'b0;
        wait_to(base + 7);
        pif.pll_locked = 1'b1;
        wait_to(base + 19);

        // 256 lock losses in RUN: loss counter saturates at 255
        for (int i = 0; i < 256; i++) begin
            base = cyc;
            pif.pll_locked = 1'b0;
            exp_ll = (exp_ll < 255) ? exp_ll + 1 : 255;
            expect_at(base + 3, vec(1'b1, 1'b1, 1'b0, exp_ll, 0));
            expect_at(base + 3 + HOLD, vec(1'b0, 1'b1, 1'b0, exp_ll, 0));
            wait_to(base + 3 + HOLD + 2);
            base = cyc;
            pif.pll_locked = 1'b1;
            expect_at(base + 3 + STABLE, vec(1'b0, 1'b0, 1'b1, exp_ll, 0));
            wait_to(base + 3 + STABLE + 2);
        end

        // Lose lock and leave it lost
        base = cyc;
        pif.pll_locked = 1'b0;
        expect_at(base + 3, vec(1'b1, 1'b1, 1'b0, exp_ll, 0));
        expect_at(base + 3 + HOLD, vec(1'b0, 1'b1, 1'b0, exp_ll, 0));
        w = base + 3 + HOLD;
`ifdef PLL_SEQ_TIMEOUT_EN
        for (int i = 0; i < 17; i++) begin
            exp_rt = (exp_rt < 15) ? exp_rt + 1 : 15;
            expect_at(w + TMO, vec(1'b1, 1'b1, 1'b0, exp_ll, exp_rt));
            expect_at(w + TMO + HOLD, vec(1'b0, 1'b1, 1'b0, exp_ll, exp_rt));
            w = w + TMO + HOLD;
        end
        wait_to(w);
`else
        wait_to(w + 100);
`endif

        // Asynchronous reset mid-WAIT_LOCK returns everything at once
        wait_to(cyc + 5);
        exp_ll = 0;
        exp_rt = 0;
        expect_at(cyc, vec(1'b1, 1'b1, 1'b0, 0, 0));
        rst = 1'b1;
        wait_to(cyc + 3);
        base = cyc;
        rst  = 1'b0;
        expect_at(base + HOLD, vec(1'b0, 1'b1, 1'b0, 0, 0));
        wait_to(base + HOLD + 5);

        tests = tests + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL pending_events got %0d outstanding expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
